write_collision_arbiter: RTL

- Sits between the NB_WRAGENT write agents and the RAM banks and the per-read-agent accounters.
- Detects same-cycle writes to the same row by different agents and lets exactly one through, chosen round-robin.
- Stalls the losing agents with a valid/ready handshake.
- Result: the downstream banks and accounters never see a write collision, so the RAM can be built without collision support.

---
 rtl/write_collision_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/write_collision_arbiter.sv
// Same-row write collision arbiter: one round-robin winner per address group, losers stalled.
// Optional per-agent stall counters enabled by defining WRITE_COLLISION_STATS_EN.
module write_collision_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int NB_WRAGENT = 2,
    parameter int PTR_WIDTH  = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
`ifdef WRITE_COLLISION_STATS_EN
    output logic [NB_WRAGENT*16-1:0]         collision_cnt,
`endif
    input  logic [NB_WRAGENT-1:0]            req_valid,
    output logic [NB_WRAGENT-1:0]            req_ready,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] req_data,
    output logic [NB_WRAGENT-1:0]            wren,
    output logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    output logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata
);

    logic [PTR_WIDTH-1:0]             r_rr_ptr;
    logic [NB_WRAGENT-1:0]            r_wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] r_wraddr;
    logic [NB_WRAGENT*DATA_WIDTH-1:0] r_wrdata;
    logic [NB_WRAGENT-1:0]            w_grant;
    logic                             w_collision;

    // Cyclic distance from the round-robin pointer; the smallest distance wins a group.
    function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned ptr);
        return (idx >= ptr) ? (idx - ptr) : (idx + NB_WRAGENT - ptr);
    endfunction

    always_comb begin
        w_grant     = '0;
        w_collision = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            w_grant[i] = req_valid[i] & aresetn;
            for (int j = 0; j < NB_WRAGENT; j++) begin
                if (j != i && req_valid[i] && req_valid[j] &&
                    req_addr[ADDR_WIDTH*i +: ADDR_WIDTH] == req_addr[ADDR_WIDTH*j +: ADDR_WIDTH])
                begin
                    w_collision = 1'b1;
                    if (rr_dist(j, 32'(r_rr_ptr)) < rr_dist(i, 32'(r_rr_ptr))) begin
                        w_grant[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rr_ptr <= '0;
            r_wren   <= '0;
            r_wraddr <= '0;
            r_wrdata <= '0;
        end else begin
            r_wren <= w_grant;
            if (w_collision) begin
                if (r_rr_ptr == PTR_WIDTH'(NB_WRAGENT - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_rr_ptr + 1'b1;
                end
            end
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (w_grant[i]) begin
                    r_wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] <= req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                    r_wrdata[DATA_WIDTH*i +: DATA_WIDTH] <= req_data[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef WRITE_COLLISION_STATS_EN
    logic [NB_WRAGENT*16-1:0] r_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (req_valid[i] && !w_grant[i] && r_cnt[16*i +: 16] != 16'hFFFF) begin
                    r_cnt[16*i +: 16] <= r_cnt[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    assign collision_cnt = r_cnt;
`endif

    assign req_ready = w_grant;
    assign wren      = r_wren;
    assign wraddr    = r_wraddr;
    assign wrdata    = r_wrdata;

endmodule
